colorbars_pattern_sequencer: RTL and testbench
==============================================

Name: colorbars_pattern_sequencer

Overview:
Control block that selects which test pattern the colour-bar datapath renders.
- Takes raw next/prev button inputs and debounces them.
- Optionally auto-advances patterns every N frames.
- Applies each pattern change only at a frame boundary, then mutes video for one full frame so the switch shows no tearing.
- Sits between the top-level ui_in pins and the pattern generator; the VGA timing generator supplies the frame_start pulse.

Parameters:
NUM_PATTERNS, 8, number of selectable patterns (2..2^PAT_W)
PAT_W, 3, width of pattern index
DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a button level (>=2)
DWELL_FRAMES, 60, frames per pattern in auto mode (>=1)

Ports:
clk  in  1  system clock (pixel clock)
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when 0 all state holds
frame_start  in  1  single-cycle pulse at start of each frame (vblank), from timing generator
btn_next  in  1  raw asynchronous button, active high
btn_prev  in  1  raw asynchronous button, active high
auto_en  in  1  level; 1 enables automatic advance
pattern  out  PAT_W  current pattern index to generator (registered)
pattern_changed  out  1  one-cycle pulse when pattern updates
mute  out  1  1 = generator must output black (registered)

Behaviour:
Reset: clk is the single clock domain. Reset is asynchronous, active-low on rst_n. On reset: pattern=0, mute=0, pattern_changed=0, state=SHOW, dwell=0, request register empty, debounced levels=0, debounce counters=0, sync flops=0.

Input conditioning:
- Each button passes through a 2-flop synchroniser into a per-button debounce counter.
- When the synchronised level differs from the debounced level, the counter increments. When they match, the counter clears.
- On reaching DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- A debounced rising edge generates an internal one-cycle request (NEXT or PREV). Falling edges generate nothing.
- NEXT and PREV requests in the same cycle cancel; no request is generated.

FSM states: SHOW, ARMED, MUTE.
- SHOW: a request latches its direction into the request register and moves to ARMED.
  - At frame_start with auto_en=1: if dwell==DWELL_FRAMES-1, advance pattern +1, set dwell=0 and go to MUTE; otherwise dwell++.
  - With auto_en=0, dwell is forced to 0.
- ARMED: a new request overwrites the latched direction (latest wins).
  - At frame_start: apply the latched direction, clear the request register, set dwell=0, go to MUTE.
  - If a request and frame_start coincide, the new request is the one applied.
- MUTE: mute=1 for the whole frame. Requests arriving in this state are discarded. At the next frame_start: mute=0, go to SHOW. No dwell counting in MUTE.

Timing and arithmetic:
- pattern, mute=1 and pattern_changed=1 all update on the clock edge that samples frame_start. They are visible in the following cycle. Latency from frame_start to new pattern is exactly 1 cycle.
- pattern_changed is high for exactly 1 cycle per change.
- Wrap-around: NEXT from NUM_PATTERNS-1 gives 0; PREV from 0 gives NUM_PATTERNS-1. Auto-advance wraps the same way as NEXT.
- Arithmetic is modulo NUM_PATTERNS, not 2^PAT_W.

ena and reset behaviour:
- ena=0: synchronisers keep sampling; debounce counters, FSM, dwell, request register and outputs hold; frame_start is ignored. pattern_changed drops to 0.
- Reset mid-operation (any state) returns immediately to the reset values above.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4, DWELL_FRAMES=3, NUM_PATTERNS=8; assert rst_n low mid-frame -> pattern=0, mute=0, pattern_changed=0 during and after reset.
- btn_next held 10 cycles, then frame_start pulse -> pattern 0->1 one cycle after frame_start; pattern_changed high 1 cycle; mute=1 until the cycle after the next frame_start.
- btn_next glitches of 2 cycles high / 2 low repeated 20 cycles, then 3 frame_starts with auto_en=0 -> pattern stays 0, mute never asserts.
- From pattern 0, debounced btn_prev then frame_start -> pattern=7. In a separate sequence, press btn_next then btn_prev before frame_start -> net PREV applied (latest wins).
- auto_en=1 from pattern 6, no buttons -> changes to 7 on the 3rd frame_start. After the MUTE frame plus 3 more frame_starts -> pattern=0 (wrap). A button press during MUTE is discarded.
- btn_next and btn_prev debounced in the same cycle -> no change. Hold ena=0 across a frame_start with ARMED -> no change; after ena returns to 1, the next frame_start applies the change.

Source files
------------

// File: rtl/colorbars_pattern_sequencer.sv
// Purpose: debounces next/prev buttons, optionally auto-advances, and applies pattern
//          changes only at frame_start, followed by one fully muted frame.
// Latency: pattern/mute/pattern_changed update on the edge that samples frame_start;
//          there is no backpressure, and ena=0 freezes all state except the synchronisers.
//
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   ena             global enable (0 = hold everything, drop pattern_changed)
//   frame_start     one-cycle frame boundary pulse from the timing generator
//   btn_next/prev   raw asynchronous buttons, active high
//   auto_en         level, enables advancing every DWELL_FRAMES frames
//   pattern         registered pattern index
//   pattern_changed one-cycle pulse on every pattern update
//   mute            registered, 1 = generator outputs black
module colorbars_pattern_sequencer #(
    parameter int NUM_PATTERNS    = 8,
    parameter int PAT_W           = 3,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int DWELL_FRAMES    = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             frame_start,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             auto_en,
    output logic [PAT_W-1:0] pattern,
    output logic             pattern_changed,
    output logic             mute
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int DW_W  = (DWELL_FRAMES > 1) ? $clog2(DWELL_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW_W-1:0]  DWELL_MAX = DW_W'(DWELL_FRAMES - 1);
    localparam logic [PAT_W-1:0] PAT_MAX   = PAT_W'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        SHOW  = 2'd0,
        ARMED = 2'd1,
        MUTE  = 2'd2
    } state_t;

    // Bit 0 = next button, bit 1 = prev button throughout.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            rise;

    logic       req_next, req_prev, req_any;

    state_t     state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [PAT_W-1:0] pat_inc, pat_dec;
    logic       mute_q, mute_d;
    logic       chg_q, chg_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic       req_vld_q, req_vld_d;
    logic       req_dir_q, req_dir_d;   // 1 = next, 0 = prev

    // Synchronisers keep sampling even while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {btn_prev, btn_next};
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level is accepted after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement with the current debounced level.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        rise  = '0;
        if (ena) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (cnt_q[i] == CNT_MAX) begin
                        deb_d[i] = sync2_q[i];
                        cnt_d[i] = '0;
                        rise[i]  = sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Simultaneous next and prev cancel each other.
    assign req_next = rise[0] & ~rise[1];
    assign req_prev = rise[1] & ~rise[0];
    assign req_any  = req_next | req_prev;

    // Wrap modulo NUM_PATTERNS, which need not be a power of two.
    assign pat_inc = (pattern_q == PAT_MAX) ? '0 : pattern_q + 1'b1;
    assign pat_dec = (pattern_q == '0) ? PAT_MAX : pattern_q - 1'b1;

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        mute_d    = mute_q;
        chg_d     = 1'b0;
        dwell_d   = dwell_q;
        req_vld_d = req_vld_q;
        req_dir_d = req_dir_q;
        if (ena) begin
            case (state_q)
                SHOW: begin
                    if (!auto_en) begin
                        dwell_d = '0;
                    end
                    // A button request takes priority over auto-advance on the same cycle.
                    if (req_any) begin
                        req_vld_d = 1'b1;
                        req_dir_d = req_next;
                        state_d   = ARMED;
                    end else if (frame_start && auto_en) begin
                        if (dwell_q == DWELL_MAX) begin
                            pattern_d = pat_inc;
                            dwell_d   = '0;
                            mute_d    = 1'b1;
                            chg_d     = 1'b1;
                            state_d   = MUTE;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (req_any) begin
                        req_dir_d = req_next;
                    end
                    if (frame_start) begin
                        // A request arriving with frame_start is the one applied.
                        pattern_d = (req_any ? req_next : req_dir_q) ? pat_inc : pat_dec;
                        req_vld_d = 1'b0;
                        dwell_d   = '0;
                        mute_d    = 1'b1;
                        chg_d     = 1'b1;
                        state_d   = MUTE;
                    end
                end
                MUTE: begin
                    if (frame_start) begin
                        mute_d  = 1'b0;
                        state_d = SHOW;
                    end
                end
                default: begin
                    state_d = SHOW;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q     <= '0;
            cnt_q     <= '0;
            state_q   <= SHOW;
            pattern_q <= '0;
            mute_q    <= 1'b0;
            chg_q     <= 1'b0;
            dwell_q   <= '0;
            req_vld_q <= 1'b0;
            req_dir_q <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            pattern_q <= pattern_d;
            mute_q    <= mute_d;
            chg_q     <= chg_d;
            dwell_q   <= dwell_d;
            req_vld_q <= req_vld_d;
            req_dir_q <= req_dir_d;
        end
    end

    assign pattern         = pattern_q;
    assign mute            = mute_q;
    assign pattern_changed = chg_q;

endmodule

// File: tb/tb_colorbars_pattern_sequencer.sv
// Bench for colorbars_pattern_sequencer: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_colorbars_pattern_sequencer;

    localparam int NP = 8;
    localparam int PW = 3;
    localparam int DC = 4;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic frame_start = 1'b0;
    logic btn_next = 1'b0;
    logic btn_prev = 1'b0;
    logic auto_en = 1'b0;
    logic [PW-1:0] pattern;
    logic pattern_changed;
    logic mute;

    int checks = 0;
    int errors = 0;

    colorbars_pattern_sequencer #(
        .NUM_PATTERNS   (NP),
        .PAT_W          (PW),
        .DEBOUNCE_CYCLES(DC),
        .DWELL_FRAMES   (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .frame_start    (frame_start),
        .btn_next       (btn_next),
        .btn_prev       (btn_prev),
        .auto_en        (auto_en),
        .pattern        (pattern),
        .pattern_changed(pattern_changed),
        .mute           (mute)
    );

    always #5 clk = ~clk;

    // Behavioural model. Mode: 0 showing, 1 change pending, 2 muted frame.
    // Direction is kept as +1 / -1 and the pattern as a plain integer mod NP.
    int m_s1 [2];
    int m_s2 [2];
    int m_deb[2];
    int m_run[2];
    int m_mode, m_dir, m_dwell, m_pat, m_mute, m_chg;

    always @(posedge clk or negedge rst_n) begin : model
        int b_in[2];
        int n_deb[2];
        int n_run[2];
        int rise[2];
        int req;
        int n_mode, n_dir, n_dwell, n_pat, n_mute, n_chg;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_s1[i]  <= 0;
                m_s2[i]  <= 0;
                m_deb[i] <= 0;
                m_run[i] <= 0;
            end
            m_mode  <= 0;
            m_dir   <= 0;
            m_dwell <= 0;
            m_pat   <= 0;
            m_mute  <= 0;
            m_chg   <= 0;
        end else begin
            b_in[0] = int'(btn_next);
            b_in[1] = int'(btn_prev);
            for (int i = 0; i < 2; i++) begin
                m_s1[i] <= b_in[i];
                m_s2[i] <= m_s1[i];
            end
            if (ena) begin
                for (int i = 0; i < 2; i++) begin
                    n_deb[i] = m_deb[i];
                    n_run[i] = 0;
                    rise[i]  = 0;
                    if (m_s2[i] != m_deb[i]) begin
                        if (m_run[i] + 1 == DC) begin
                            n_deb[i] = m_s2[i];
                            rise[i]  = m_s2[i];
                        end else begin
                            n_run[i] = m_run[i] + 1;
                        end
                    end
                    m_deb[i] <= n_deb[i];
                    m_run[i] <= n_run[i];
                end
                req     = rise[0] - rise[1];
                n_mode  = m_mode;
                n_dir   = m_dir;
                n_dwell = m_dwell;
                n_pat   = m_pat;
                n_mute  = m_mute;
                n_chg   = 0;
                if (m_mode == 0) begin
                    if (!auto_en) n_dwell = 0;
                    if (req != 0) begin
                        n_dir  = req;
                        n_mode = 1;
                    end else if (frame_start && auto_en) begin
                        if (m_dwell + 1 == DW) begin
                            n_pat   = (m_pat + 1) % NP;
                            n_dwell = 0;
                            n_mode  = 2;
                            n_mute  = 1;
                            n_chg   = 1;
                        end else begin
                            n_dwell = m_dwell + 1;
                        end
                    end
                end else if (m_mode == 1) begin
                    if (req != 0) n_dir = req;
                    if (frame_start) begin
                        n_pat   = (m_pat + n_dir + NP) % NP;
                        n_dwell = 0;
                        n_mode  = 2;
                        n_mute  = 1;
                        n_chg   = 1;
                    end
                end else begin
                    if (frame_start) begin
                        n_mute = 0;
                        n_mode = 0;
                    end
                end
                m_mode  <= n_mode;
                m_dir   <= n_dir;
                m_dwell <= n_dwell;
                m_pat   <= n_pat;
                m_mute  <= n_mute;
                m_chg   <= n_chg;
            end else begin
                m_chg <= 0;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle; outputs are compared with the model on the falling edge.
    task automatic tick();
        @(negedge clk);
        cmp("pattern", 32'(pattern), 32'(m_pat));
        cmp("mute", 32'(mute), 32'(m_mute));
        cmp("pattern_changed", 32'(pattern_changed), 32'(m_chg));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // which: 0 = next, 1 = prev, 2 = both together
    task automatic press(input int which);
        if (which != 1) btn_next = 1'b1;
        if (which != 0) btn_prev = 1'b1;
        ticks(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        ticks(10);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
    endtask

    initial begin
        int fs_cnt;
        int period;
        ena = 1'b1;
        do_reset();
        cmp("reset_pattern", 32'(pattern), 0);
        cmp("reset_mute", 32'(mute), 0);

        // Reset while a change is pending must discard it.
        btn_next = 1'b1;
        ticks(8);
        rst_n = 1'b0;
        ticks(2);
        cmp("midreset_pattern", 32'(pattern), 0);
        cmp("midreset_changed", 32'(pattern_changed), 0);
        cmp("midreset_mute", 32'(mute), 0);
        rst_n = 1'b1;
        btn_next = 1'b0;
        ticks(10);
        frame();
        cmp("after_reset_frame", 32'(pattern), 0);

        // Debounced next applied at frame_start, then a muted frame.
        press(0);
        ticks(3);
        frame();
        cmp("next_pattern", 32'(pattern), 1);
        cmp("next_changed", 32'(pattern_changed), 1);
        cmp("next_mute", 32'(mute), 1);
        tick();
        cmp("next_changed_pulse", 32'(pattern_changed), 0);
        ticks(10);
        cmp("mute_held", 32'(mute), 1);
        frame();
        cmp("mute_released", 32'(mute), 0);
        cmp("pattern_kept", 32'(pattern), 1);

        // Short glitches never pass the debouncer.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            btn_next = 1'b1;
            ticks(2);
            btn_next = 1'b0;
            ticks(2);
        end
        ticks(5);
        for (int f = 0; f < 3; f++) begin
            frame();
            ticks(5);
        end
        cmp("glitch_pattern", 32'(pattern), 0);
        cmp("glitch_mute", 32'(mute), 0);

        // prev wraps 0 -> 7, then next+prev: latest (prev) wins.
        press(1);
        frame();
        cmp("prev_wrap", 32'(pattern), 7);
        ticks(4);
        frame();
        press(0);
        press(1);
        frame();
        cmp("latest_wins", 32'(pattern), 6);
        ticks(4);
        frame();

        // Auto-advance every 3 frames, wrap 7 -> 0, press during mute ignored.
        auto_en = 1'b1;
        frame();
        ticks(5);
        frame();
        ticks(5);
        cmp("auto_wait", 32'(pattern), 6);
        frame();
        cmp("auto_advance", 32'(pattern), 7);
        press(0);
        frame();
        cmp("mute_press_dropped", 32'(pattern), 7);
        cmp("auto_mute_off", 32'(mute), 0);
        frame();
        ticks(5);
        frame();
        ticks(5);
        frame();
        cmp("auto_wrap", 32'(pattern), 0);
        auto_en = 1'b0;
        ticks(5);
        frame();

        // Simultaneous presses cancel.
        press(2);
        frame();
        cmp("both_cancel", 32'(pattern), 0);
        cmp("both_no_mute", 32'(mute), 0);

        // ena=0 across frame_start holds a pending change.
        press(0);
        ena = 1'b0;
        ticks(3);
        frame();
        ticks(3);
        cmp("ena_hold_pattern", 32'(pattern), 0);
        cmp("ena_hold_mute", 32'(mute), 0);
        ena = 1'b1;
        ticks(2);
        frame();
        cmp("ena_resume_pattern", 32'(pattern), 1);
        cmp("ena_resume_changed", 32'(pattern_changed), 1);
        ticks(3);
        frame();

        // Randomized run.
        auto_en = 1'b1;
        fs_cnt  = 0;
        period  = 20;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) btn_next = ~btn_next;
            if ($urandom_range(7) == 0) btn_prev = ~btn_prev;
            if ($urandom_range(199) == 0) auto_en = ~auto_en;
            ena = ($urandom_range(15) != 0);
            frame_start = 1'b0;
            if (fs_cnt >= period) begin
                frame_start = 1'b1;
                fs_cnt = 0;
                period = $urandom_range(30, 12);
            end else begin
                fs_cnt++;
            end
            if (c == 2000) rst_n = 1'b0;
            if (c == 2003) rst_n = 1'b1;
            tick();
        end
        frame_start = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
